// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single outstanding imem requests
// and buffers returned instructions in a 2-entry queue feeding the IF/ID register.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_if_stage #(
    parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_stall,
    input  logic              i_redirect,
    input  logic [`XLEN-1:0]  i_redirect_pc,
    output logic              o_imem_req,
    output logic [`XLEN-1:0]  o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [`XLEN-1:0]  i_imem_rdata,
    output logic              o_if_valid,
    output logic [`XLEN-1:0]  o_if_instr,
    output logic [`XLEN-1:0]  o_if_pc,
    output logic [`XLEN-1:0]  o_if_pc_plus_4
);

    localparam logic [`XLEN-1:0] NOP = 32'h0000_0013;

    logic [`XLEN-1:0] pc_q;
    logic [`XLEN-1:0] pend_pc;
    logic             outstanding;
    logic             kill;
    logic [`XLEN-1:0] q_instr [2];
    logic [`XLEN-1:0] q_pc    [2];
    logic [1:0]       count;

    logic             grant;
    logic             resp;
    logic             push;
    logic             pop;
    logic [`XLEN-1:0] redirect_target;

    always_comb begin
        o_imem_req      = !i_rst && !i_redirect && !outstanding && (count < 2'd2);
        grant           = o_imem_req && i_imem_gnt;
        // A response is only honoured while one is actually owed; strays are ignored.
        resp            = i_imem_rvalid && outstanding;
        push            = resp && !kill && !i_redirect;
        pop             = (count != 2'd0) && !i_id_stall && !i_redirect;
        redirect_target = i_redirect_pc & ~32'h0000_0003;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            pend_pc     <= '0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            count       <= '0;
            q_instr[0]  <= '0;
            q_instr[1]  <= '0;
            q_pc[0]     <= '0;
            q_pc[1]     <= '0;
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end

            // The arriving response is the one kill guarded, so it always clears kill.
            if (resp) begin
                kill <= 1'b0;
            end else if (i_redirect && outstanding) begin
                kill <= 1'b1;
            end

            if (i_redirect) begin
                pc_q  <= redirect_target;
                count <= '0;
            end else begin
                if (grant) begin
                    pend_pc <= pc_q;
                    pc_q    <= pc_q + 32'd4;
                end
                case ({push, pop})
                    2'b01: begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        count      <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) begin
                            q_instr[0] <= i_imem_rdata;
                            q_pc[0]    <= pend_pc;
                            count      <= 2'd1;
                        end else if (count == 2'd1) begin
                            q_instr[1] <= i_imem_rdata;
                            q_pc[1]    <= pend_pc;
                            count      <= 2'd2;
                        end
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            q_instr[0] <= i_imem_rdata;
                            q_pc[0]    <= pend_pc;
                        end else begin
                            q_instr[0] <= q_instr[1];
                            q_pc[0]    <= q_pc[1];
                            q_instr[1] <= i_imem_rdata;
                            q_pc[1]    <= pend_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_imem_addr    = pc_q;
        o_if_valid     = (count != 2'd0);
        o_if_instr     = o_if_valid ? q_instr[0] : NOP;
        o_if_pc        = o_if_valid ? q_pc[0] : '0;
        o_if_pc_plus_4 = o_if_valid ? q_pc[0] + 32'd4 : '0;
    end

endmodule

// File: tb/tb_riscv_if_stage.sv
// Bench for riscv_if_stage: directed scenarios plus randomized traffic against a
// queue-based reference model and a simple variable-latency memory.
module tb_riscv_if_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_id_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc_plus_4;

    always #5 i_clk = ~i_clk;

    riscv_if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_id_stall     (i_id_stall),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_if_valid     (o_if_valid),
        .o_if_instr     (o_if_instr),
        .o_if_pc        (o_if_pc),
        .o_if_pc_plus_4 (o_if_pc_plus_4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetch PC, one in-flight slot, a kill flag and a queue of {instr, pc}.
    logic [31:0] m_pc = '0;
    logic [31:0] m_pend = '0;
    bit          m_out = 0;
    bit          m_kill = 0;
    logic [63:0] mq[$];

    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gnt_pct = 100;
    bit          force_rv = 0;
    logic [31:0] pops[$];

    task automatic reset_async();
        i_id_stall    = 1'b0;
        i_redirect    = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("rst_req",   o_imem_req,     32'd0);
        check("rst_addr",  o_imem_addr,    32'h0);
        check("rst_valid", o_if_valid,     32'd0);
        check("rst_instr", o_if_instr,     32'h0000_0013);
        check("rst_pc",    o_if_pc,        32'h0);
        check("rst_pc4",   o_if_pc_plus_4, 32'h0);
        m_pc = '0; m_pend = '0; m_out = 0; m_kill = 0; mq.delete();
        mem_busy = 0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
        bit          e_req, gnt, rv;
        logic [31:0] e_pc, old_pc, rdata;
        i_id_stall    = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
        i_imem_rvalid = (mem_busy && mem_cnt == 1) || force_rv;
        i_imem_rdata  = (mem_busy && mem_cnt == 1) ? mem_addr + 32'h100 : $urandom;
        force_rv = 0;
        #1;
        e_req = !redir && !m_out && (mq.size() < 2);
        e_pc  = (mq.size() > 0) ? mq[0][31:0] : 32'h0;
        check("req",   o_imem_req, e_req);
        check("addr",  o_imem_addr, m_pc);
        check("valid", o_if_valid, mq.size() > 0);
        check("instr", o_if_instr, (mq.size() > 0) ? mq[0][63:32] : 32'h0000_0013);
        check("pc",    o_if_pc, e_pc);
        check("pc4",   o_if_pc_plus_4, (mq.size() > 0) ? e_pc + 32'd4 : 32'h0);
        if (mq.size() > 0 && !stall && !redir) pops.push_back(o_if_pc);
        gnt    = i_imem_gnt;
        rv     = i_imem_rvalid && m_out;
        rdata  = i_imem_rdata;
        old_pc = m_pc;
        @(posedge i_clk);
        if (redir) begin
            m_pc = rpc & ~32'h3;
            mq.delete();
            if (rv) begin
                m_out = 0; m_kill = 0;
            end else if (m_out) begin
                m_kill = 1;
            end
        end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (e_req && gnt) begin
                m_pend = m_pc; m_pc = m_pc + 32'd4; m_out = 1;
            end
            if (rv) begin
                m_out = 0;
                if (m_kill) m_kill = 0;
                else mq.push_back({rdata, m_pend});
            end
        end
        if (mem_busy) begin
            if (mem_cnt == 1) mem_busy = 0;
            else mem_cnt--;
        end
        if (e_req && gnt) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            mem_addr = old_pc;
        end
        #1;
    endtask

    initial begin
        bit found;
        logic [31:0] tgt;
        @(posedge i_clk);
        #1;
        reset_async();

        // Back-to-back fetch with a 1-cycle memory: heads 0, 4, 8.
        pops.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        check("seq_pop0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h0);
        check("seq_pop1", (pops.size() > 1) ? pops[1] : 32'hDEAD_BEEF, 32'h4);
        check("seq_pop2", (pops.size() > 2) ? pops[2] : 32'hDEAD_BEEF, 32'h8);

        // Stall fills the queue; request must stop, then pops come out in order.
        reset_async();
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        check("stall_req", o_imem_req, 32'd0);
        check("stall_head", o_if_pc, 32'h0);
        pops.delete();
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        check("stall_pop0", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h0);
        check("stall_pop1", (pops.size() > 1) ? pops[1] : 32'hDEAD_BEEF, 32'h4);

        // Redirect while the fetch of 0x8 is in flight; its data must never appear.
        reset_async();
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_out && m_pend == 32'h8 && !(mem_busy && mem_cnt == 1)) found = 1;
            else step(0, 0, 0);
        end
        check("kill_setup", found, 32'd1);
        step(0, 1, 32'h200);
        pops.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        check("kill_first", (pops.size() > 0) ? pops[0] : 32'hDEAD_BEEF, 32'h200);

        // Redirect coinciding with a response and a pop.
        reset_async();
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() > 0 && mem_busy && mem_cnt == 1 && m_out && !m_kill) found = 1;
            else step(1, 0, 0);
        end
        check("coinc_setup", found, 32'd1);
        step(0, 1, 32'h200);
        i_redirect = 1'b0;
        #1;
        check("coinc_valid", o_if_valid, 32'd0);
        check("coinc_addr", o_imem_addr, 32'h200);
        check("coinc_req", o_imem_req, 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // Misaligned redirect target and PC wrap.
        step(0, 1, 32'h203);
        i_redirect = 1'b0;
        #1;
        check("align_addr", o_imem_addr, 32'h200);
        reset_async();
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0);
        check("wrap_addr", o_imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // Asynchronous reset while waiting on memory, then a stale response.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !m_out; i++) step(0, 0, 0);
        check("arst_setup", m_out, 32'd1);
        reset_async();
        force_rv = 1;
        step(0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // Randomized traffic.
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                reset_async();
                force_rv = $urandom_range(1, 0);
            end
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_if_stage.md
# riscv_if_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the fetch PC, issues one-at-a-time requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a 2-entry queue. The queue head drives the IF-side inputs of `riscv_ifid_reg` (instr, pc, pc_plus_4). Honours the same ID stall, and handles EX-stage redirects (taken branch or jump) by flushing the queue and discarding in-flight responses.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits[1:0] must be 0.

All data widths are `` `XLEN `` (32).

Ports:
- `i_clk`  in  1  clock; all state on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_id_stall`  in  1  ID stall; IF/ID holds, so the queue head is not consumed.
- `i_redirect`  in  1  taken branch or jump from EX.
- `i_redirect_pc`  in  XLEN  redirect target.
- `o_imem_req`  out  1  fetch request valid.
- `o_imem_addr`  out  XLEN  fetch address; always equals pc_q.
- `i_imem_gnt`  in  1  request accepted this cycle; only meaningful while `o_imem_req`=1.
- `i_imem_rvalid`  in  1  response valid; at least 1 cycle after grant, at most one per grant.
- `i_imem_rdata`  in  XLEN  instruction word.
- `o_if_valid`  out  1  queue head is valid.
- `o_if_instr`  out  XLEN  head instruction; 32'h0000_0013 (NOP) when empty.
- `o_if_pc`  out  XLEN  head PC; 0 when empty.
- `o_if_pc_plus_4`  out  XLEN  head PC+4; 0 when empty.

## Operation
State:
- pc_q: next fetch address.
- pend_pc: PC of the in-flight request.
- outstanding: 1 while a granted request awaits its response.
- kill: 1 when the in-flight response must be dropped.
- 2-entry FIFO of {instr, pc}, with count 0..2.

Request rule:
- `o_imem_req` = !i_rst && !i_redirect && !outstanding && (count < 2).
- Count includes no pending pop.
- Only one request may be outstanding at a time.

Grant (req && gnt):
- pend_pc <= pc_q.
- pc_q <= pc_q + 4, wrapping modulo 2^32.
- outstanding <= 1.

Response (rvalid):
- outstanding <= 0.
- If kill=0, push {rdata, pend_pc}.
- If kill=1, discard the data and clear kill.

Pop: when o_if_valid && !i_id_stall. A push and a pop in the same cycle leave count unchanged.

Push into a full queue is impossible by the request rule. If it occurs anyway, the push is dropped; the checker flags it as an error.

Redirect has top priority in its cycle:
- pc_q <= {i_redirect_pc[31:2], 2'b00}.
- The queue is flushed (count <= 0). Any same-cycle push or pop is ignored.
- If outstanding=1 and there is no same-cycle rvalid, kill <= 1.
- A same-cycle rvalid is dropped and does not set kill.
- A redirect while kill=1 keeps kill=1.

o_if_pc_plus_4 = o_if_pc + 4, computed from the head entry. It is 0 when the queue is empty.

## Timing
Reset (i_rst=1, async): pc_q=RESET_PC, count=0, outstanding=0, kill=0. This gives:
- o_imem_req=0
- o_imem_addr=RESET_PC
- o_if_valid=0
- o_if_instr=32'h0000_0013
- o_if_pc=0
- o_if_pc_plus_4=0

Reset asserted mid-operation drops any in-flight response. A response arriving after reset release with outstanding=0 is ignored.

Latencies:
- Cycle 0 after reset release: o_imem_req=1.
- Grant in cycle N: o_imem_req=0 in cycle N+1, until the response.
- rvalid in cycle M: o_if_valid=1 (or the queue advances) from cycle M+1. A new request is allowed in M+1 if count<2.
- Redirect in cycle R: o_if_valid=0 and o_imem_addr=target in R+1. o_imem_req=1 in R+1 only if outstanding=0.
- Peak throughput is one instruction per 2 cycles with a 1-cycle-latency memory.

## Test plan
- Reset release, RESET_PC=0, gnt=1 always, rvalid 1 cycle after grant with rdata=addr|0x100 → addresses 0, 4, 8 issued. The head sequence is pc 0/4/8, instr 0x100/0x104/0x108, pc_plus_4 4/8/12.
- i_id_stall=1 for 6 cycles from the first valid → the queue fills to 2 (pc 0, 4) and o_imem_req holds 0. Release the stall → pop order is 0 then 4, with no duplicate or loss.
- Redirect to 0x200 while a request to 0x8 is outstanding, response 3 cycles later → the 0x8 data is never presented. The first valid head has pc=0x200.
- Redirect coinciding with rvalid and a pop → the queue is empty next cycle, kill=0, and the next request address is 0x200.
- Redirect target 0x203 → fetch address 0x200. Fetch from 0xFFFF_FFFC → the next address is 0x0000_0000.
- i_rst asserted asynchronously mid-wait → all outputs take reset values immediately. A stale rvalid after release is ignored.
